cpu_multicycle: RTL

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_pkg.sv | 112 +++++++++++
 rtl/cpu_multicycle_regfile.sv | 50 +++++
 rtl/cpu_multicycle.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared opcodes, FSM state and ALU op encodings plus the
//          instruction decoder used by cpu_multicycle. Macro
//          CPU_SERIAL_SHIFT_EN adds the SHIFT state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;

    localparam logic [2:0] c_f3_add  = 3'b000;
    localparam logic [2:0] c_f3_sll  = 3'b001;
    localparam logic [2:0] c_f3_slt  = 3'b010;
    localparam logic [2:0] c_f3_sltu = 3'b011;
    localparam logic [2:0] c_f3_xor  = 3'b100;
    localparam logic [2:0] c_f3_srl  = 3'b101;
    localparam logic [2:0] c_f3_or   = 3'b110;
    localparam logic [2:0] c_f3_and  = 3'b111;

    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
`ifdef CPU_SERIAL_SHIFT_EN
        S_SHIFT  = 3'd3,
`endif
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef struct packed {
        alu_op_t op;
        logic    legal;
        logic    use_imm;
    } dec_t;

    // On RV64 instruction[25] is shamt[5], so only [31:26] is the shift funct.
    function automatic dec_t decode_op(input logic [31:0] ir, input logic xlen64);
        dec_t d;
        d.op      = ALU_ADD;
        d.legal   = 1'b0;
        d.use_imm = 1'b0;
        case (ir[6:0])
            c_opc_op_imm: begin
                d.use_imm = 1'b1;
                d.legal   = 1'b1;
                case (ir[14:12])
                    c_f3_add:  d.op = ALU_ADD;
                    c_f3_slt:  d.op = ALU_SLT;
                    c_f3_sltu: d.op = ALU_SLTU;
                    c_f3_xor:  d.op = ALU_XOR;
                    c_f3_or:   d.op = ALU_OR;
                    c_f3_and:  d.op = ALU_AND;
                    c_f3_sll: begin
                        d.op    = ALU_SLL;
                        d.legal = (ir[31:26] == 6'b000000) && (xlen64 || !ir[25]);
                    end
                    default: begin
                        d.op    = ir[30] ? ALU_SRA : ALU_SRL;
                        d.legal = ((ir[31:26] == 6'b000000) || (ir[31:26] == 6'b010000))
                                  && (xlen64 || !ir[25]);
                    end
                endcase
            end
            c_opc_op: begin
                d.legal = 1'b1;
                if (ir[31:25] == c_f7_base) begin
                    case (ir[14:12])
                        c_f3_add:  d.op = ALU_ADD;
                        c_f3_sll:  d.op = ALU_SLL;
                        c_f3_slt:  d.op = ALU_SLT;
                        c_f3_sltu: d.op = ALU_SLTU;
                        c_f3_xor:  d.op = ALU_XOR;
                        c_f3_srl:  d.op = ALU_SRL;
                        c_f3_or:   d.op = ALU_OR;
                        default:   d.op = ALU_AND;
                    endcase
                end else if (ir[31:25] == c_f7_alt && ir[14:12] == c_f3_add) begin
                    d.op = ALU_SUB;
                end else if (ir[31:25] == c_f7_alt && ir[14:12] == c_f3_srl) begin
                    d.op = ALU_SRA;
                end else begin
                    d.legal = 1'b0;
                end
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_multicycle_regfile.sv
// ============================================================================
// Module : regfile
// Brief  : NREGS x XLEN register file, two async read ports, one write port,
//          x0 and out-of-range indices read as zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_raddr_a,
    input  logic [4:0]      i_raddr_b,
    output logic [XLEN-1:0] o_rdata_a,
    output logic [XLEN-1:0] o_rdata_b,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    localparam int c_aw = $clog2(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_ok;
    logic            w_ra_ok;
    logic            w_rb_ok;

    assign w_wr_ok = (i_waddr != 5'd0) && ({27'd0, i_waddr} < 32'(NREGS));
    assign w_ra_ok = (i_raddr_a != 5'd0) && ({27'd0, i_raddr_a} < 32'(NREGS));
    assign w_rb_ok = (i_raddr_b != 5'd0) && ({27'd0, i_raddr_b} < 32'(NREGS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && w_wr_ok) begin
            r_regs[i_waddr[c_aw-1:0]] <= i_wdata;
        end
    end

    assign o_rdata_a = w_ra_ok ? r_regs[i_raddr_a[c_aw-1:0]] : '0;
    assign o_rdata_b = w_rb_ok ? r_regs[i_raddr_b[c_aw-1:0]] : '0;

endmodule

`default_nettype wire

// File: rtl/cpu_multicycle.sv
// ============================================================================
// Module : cpu_multicycle
// Brief  : Multicycle RV32I/RV64I OP/OP-IMM core. Define CPU_SERIAL_SHIFT_EN
//          to replace the barrel shifter with a 1-bit-per-cycle SHIFT state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [XLEN-1:0] PC_out,
    output logic [7:0]      LED,
    output logic            retire,
    output logic            illegal,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    localparam int   c_shw    = $clog2(XLEN);
    localparam logic c_xlen64 = (XLEN == 64);

    state_t          r_state;
    logic            r_ready;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    alu_op_t         r_op;
    logic            r_legal;
    logic [4:0]      r_rd;
    logic [7:0]      r_led;
    logic            r_retire;
    logic            r_illegal;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    dec_t            w_dec;
    logic            w_idx_ok;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [XLEN-1:0] w_imm;
    logic [c_shw-1:0] w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_result;
    logic            w_commit;
    logic            w_we;

    function automatic logic idx_ok(input logic [4:0] idx);
        return {27'd0, idx} < 32'(NREGS);
    endfunction

    assign w_dec    = decode_op(r_ir, c_xlen64);
    assign w_idx_ok = idx_ok(r_ir[11:7]) && idx_ok(r_ir[19:15])
                      && (w_dec.use_imm || idx_ok(r_ir[24:20]));
    assign w_imm    = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    assign w_shamt  = r_b[c_shw-1:0];

    regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_raddr_a (r_ir[19:15]),
        .i_raddr_b (r_ir[24:20]),
        .o_rdata_a (w_rs1_data),
        .o_rdata_b (w_rs2_data),
        .i_we      (w_we),
        .i_waddr   (r_rd),
        .i_wdata   (w_result)
    );

    always_comb begin
        w_alu = '0;
        case (r_op)
            ALU_ADD:  w_alu = r_a + r_b;
            ALU_SUB:  w_alu = r_a - r_b;
            ALU_SLT:  w_alu[0] = $signed(r_a) < $signed(r_b);
            ALU_SLTU: w_alu[0] = r_a < r_b;
            ALU_XOR:  w_alu = r_a ^ r_b;
            ALU_OR:   w_alu = r_a | r_b;
            ALU_AND:  w_alu = r_a & r_b;
`ifdef CPU_SERIAL_SHIFT_EN
            // Only reached with shamt == 0; nonzero shifts go through SHIFT.
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu = r_a;
`else
            ALU_SLL:  w_alu = r_a << w_shamt;
            ALU_SRL:  w_alu = r_a >> w_shamt;
            ALU_SRA:  w_alu = $signed(r_a) >>> w_shamt;
`endif
            default:  w_alu = '0;
        endcase
    end

`ifdef CPU_SERIAL_SHIFT_EN
    logic [XLEN-1:0]  r_sh;
    logic [c_shw-1:0] r_cnt;
    logic [XLEN-1:0]  w_sh_next;
    logic             w_go_shift;

    always_comb begin
        case (r_op)
            ALU_SLL: w_sh_next = {r_sh[XLEN-2:0], 1'b0};
            ALU_SRA: w_sh_next = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
            default: w_sh_next = {1'b0, r_sh[XLEN-1:1]};
        endcase
    end

    assign w_go_shift = r_legal && (w_shamt != '0)
                        && (r_op == ALU_SLL || r_op == ALU_SRL || r_op == ALU_SRA);
    assign w_commit   = ((r_state == S_EXEC) && !w_go_shift)
                        || ((r_state == S_SHIFT) && (r_cnt == c_shw'(1)));
    assign w_result   = (r_state == S_SHIFT) ? w_sh_next : w_alu;
`else
    assign w_commit   = (r_state == S_EXEC);
    assign w_result   = w_alu;
`endif

    // Architectural state commits on the edge into WB; retire marks that edge.
    assign w_we = w_commit && r_legal && (r_rd != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ready   <= 1'b0;
            r_ir      <= '0;
            r_pc      <= RESET_PC;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= ALU_ADD;
            r_legal   <= 1'b0;
            r_rd      <= '0;
            r_led     <= '0;
            r_retire  <= 1'b0;
            r_illegal <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
`ifdef CPU_SERIAL_SHIFT_EN
            r_sh      <= '0;
            r_cnt     <= '0;
`endif
        end else begin
            r_retire  <= 1'b0;
            r_illegal <= 1'b0;
            if (w_commit) begin
                r_state   <= S_WB;
                r_retire  <= 1'b1;
                r_illegal <= !r_legal;
                r_wb_rd   <= r_rd;
                r_wb_data <= r_legal ? w_result : '0;
                r_pc      <= r_pc + XLEN'(4);
                if (w_we) begin
                    r_led <= w_result[7:0];
                end
            end
            case (r_state)
                S_FETCH: begin
                    if (r_ready && instr_valid) begin
                        r_ir    <= instruction;
                        r_ready <= 1'b0;
                        r_state <= S_DECODE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_a     <= w_rs1_data;
                    r_b     <= w_dec.use_imm ? w_imm : w_rs2_data;
                    r_op    <= w_dec.op;
                    r_legal <= w_dec.legal && w_idx_ok;
                    r_rd    <= r_ir[11:7];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
`ifdef CPU_SERIAL_SHIFT_EN
                    if (!w_commit) begin
                        r_sh    <= r_a;
                        r_cnt   <= w_shamt;
                        r_state <= S_SHIFT;
                    end
`endif
                end
`ifdef CPU_SERIAL_SHIFT_EN
                S_SHIFT: begin
                    if (!w_commit) begin
                        r_sh  <= w_sh_next;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_WB: begin
                    r_state <= S_FETCH;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign PC_out      = r_pc;
    assign LED         = r_led;
    assign retire      = r_retire;
    assign illegal     = r_illegal;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;

endmodule

`default_nettype wire
